// File: rtl/relay_station_monitored.sv
// Long-distance stream relay: LEVEL register stages in each direction feeding a
// first-word fall-through FIFO sized to absorb every in-flight word, plus occupancy monitors.
module relay_station_monitored #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int LEVEL      = 2,
   localparam int GRACE     = 2 * LEVEL,
   localparam int CAP       = DEPTH + GRACE,
   localparam int AW        = (CAP > 1) ? $clog2(CAP) : 1,
   localparam int CW        = $clog2(CAP + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic [CW-1:0]         occupancy,
   output logic [CW-1:0]         max_occupancy,
   input  logic                  clear_max,
   output logic                  overflow
);

   logic                  accept;
   logic                  push;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  pop;
   logic                  ready_int;
   logic                  full;
   logic                  do_write;

   logic [DATA_WIDTH-1:0] mem [CAP];
   logic [AW-1:0]         waddr_reg;
   logic [AW-1:0]         raddr_reg;
   logic [CW-1:0]         count_reg;
   logic [CW-1:0]         count_next;
   logic [CW-1:0]         max_reg;
   logic                  overflow_reg;

   assign accept = if_write & if_write_ce & if_full_n;

   generate
      if (LEVEL == 0) begin : g_no_stage
         assign push      = accept;
         assign push_data = if_din;
         assign if_full_n = ready_int;
      end else begin : g_stage
         logic                  fwd_valid_reg [LEVEL];
         logic [DATA_WIDTH-1:0] fwd_data_reg  [LEVEL];
         logic                  bwd_ready_reg [LEVEL];

         // Valid and ready chains are cleared so no stale word or stale credit survives reset.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < LEVEL; i++) begin
                  fwd_valid_reg[i] <= 1'b0;
                  bwd_ready_reg[i] <= 1'b0;
               end
            end else begin
               fwd_valid_reg[0] <= accept;
               bwd_ready_reg[0] <= ready_int;
               for (int i = 1; i < LEVEL; i++) begin
                  fwd_valid_reg[i] <= fwd_valid_reg[i-1];
                  bwd_ready_reg[i] <= bwd_ready_reg[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            fwd_data_reg[0] <= if_din;
            for (int i = 1; i < LEVEL; i++) begin
               fwd_data_reg[i] <= fwd_data_reg[i-1];
            end
         end

         assign push      = fwd_valid_reg[LEVEL-1];
         assign push_data = fwd_data_reg[LEVEL-1];
         assign if_full_n = bwd_ready_reg[LEVEL-1];
      end
   endgenerate

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] ptr);
      return (ptr == AW'(CAP - 1)) ? '0 : ptr + AW'(1);
   endfunction

   assign ready_int  = (count_reg < CW'(DEPTH));
   assign if_empty_n = (count_reg != '0);
   assign pop        = if_read & if_read_ce & if_empty_n;
   assign full       = (count_reg == CW'(CAP));
   // When full, a push can only land in the slot being vacated by a simultaneous pop.
   assign do_write   = push & (~full | pop);

   always_comb begin
      count_next = count_reg;
      if (do_write && !pop) begin
         count_next = count_reg + CW'(1);
      end else if (pop && !do_write) begin
         count_next = count_reg - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         waddr_reg    <= '0;
         raddr_reg    <= '0;
         count_reg    <= '0;
         max_reg      <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (do_write) begin
            waddr_reg <= wrap_inc(waddr_reg);
         end
         if (pop) begin
            raddr_reg <= wrap_inc(raddr_reg);
         end
         count_reg <= count_next;
         if (push && !pop && full) begin
            overflow_reg <= 1'b1;
         end
         if (clear_max) begin
            max_reg <= '0;
         end else if (count_next > max_reg) begin
            max_reg <= count_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[waddr_reg] <= push_data;
      end
   end

   assign if_dout       = mem[raddr_reg];
   assign occupancy     = count_reg;
   assign max_occupancy = max_reg;
   assign overflow      = overflow_reg;

endmodule

// File: tb/tb_relay_station_monitored.sv
// Bench for relay_station_monitored: three configurations checked against a
// queue-based model of words stored, words in flight and the delayed ready rule.
module tb_relay_station_monitored;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst [3];
   logic          wr [3], wce [3], rd [3], rce [3], clr [3];
   logic [DW-1:0] din [3];
   logic          full_n [3], empty_n [3], ovf [3];
   logic [DW-1:0] dout [3];
   logic [3:0]    occ [3], mx [3];
   logic [3:0]    occ_a, mx_a;
   logic [2:0]    occ_b, mx_b;
   logic [1:0]    occ_c, mx_c;

   assign occ[0] = occ_a;
   assign mx[0]  = mx_a;
   assign occ[1] = {1'b0, occ_b};
   assign mx[1]  = {1'b0, mx_b};
   assign occ[2] = {2'b00, occ_c};
   assign mx[2]  = {2'b00, mx_c};

   relay_station_monitored #(.DATA_WIDTH(DW), .DEPTH(4), .LEVEL(2)) dut_a (
      .clk(clk), .reset(rst[0]), .if_full_n(full_n[0]), .if_write_ce(wce[0]),
      .if_write(wr[0]), .if_din(din[0]), .if_empty_n(empty_n[0]), .if_read_ce(rce[0]),
      .if_read(rd[0]), .if_dout(dout[0]), .occupancy(occ_a), .max_occupancy(mx_a),
      .clear_max(clr[0]), .overflow(ovf[0]));

   relay_station_monitored #(.DATA_WIDTH(DW), .DEPTH(5), .LEVEL(1)) dut_b (
      .clk(clk), .reset(rst[1]), .if_full_n(full_n[1]), .if_write_ce(wce[1]),
      .if_write(wr[1]), .if_din(din[1]), .if_empty_n(empty_n[1]), .if_read_ce(rce[1]),
      .if_read(rd[1]), .if_dout(dout[1]), .occupancy(occ_b), .max_occupancy(mx_b),
      .clear_max(clr[1]), .overflow(ovf[1]));

   relay_station_monitored #(.DATA_WIDTH(DW), .DEPTH(3), .LEVEL(0)) dut_c (
      .clk(clk), .reset(rst[2]), .if_full_n(full_n[2]), .if_write_ce(wce[2]),
      .if_write(wr[2]), .if_din(din[2]), .if_empty_n(empty_n[2]), .if_read_ce(rce[2]),
      .if_read(rd[2]), .if_dout(dout[2]), .occupancy(occ_c), .max_occupancy(mx_c),
      .clear_max(clr[2]), .overflow(ovf[2]));

   int checks = 0;
   int errors = 0;

   // Model: stored words, words in flight with their arrival cycle, and count history.
   int            sel, lvl, dep, cap, cyc, mmax;
   logic [DW-1:0] q [$];
   int            due_q [$];
   logic [DW-1:0] dat_q [$];
   int            hist [256];
   logic          m_ovf;
   logic          exp_full_n, exp_empty_n;
   logic [DW-1:0] exp_dout;
   int            exp_occ, exp_max;

   task automatic model_view();
      hist[cyc % 256] = q.size();
      exp_full_n  = (cyc >= lvl) ? (hist[(cyc - lvl) % 256] < dep) : 1'b0;
      exp_empty_n = (q.size() != 0);
      exp_dout    = (q.size() != 0) ? q[0] : '0;
      exp_occ     = q.size();
      exp_max     = mmax;
   endtask

   task automatic model_reset(input int s);
      sel = s;
      case (s)
         0:       begin dep = 4; lvl = 2; end
         1:       begin dep = 5; lvl = 1; end
         default: begin dep = 3; lvl = 0; end
      endcase
      cap   = dep + 2 * lvl;
      cyc   = 0;
      mmax  = 0;
      m_ovf = 1'b0;
      q.delete();
      due_q.delete();
      dat_q.delete();
   endtask

   task automatic do_reset(input int s);
      wr[s] = 0; wce[s] = 0; rd[s] = 0; rce[s] = 0; clr[s] = 0; din[s] = '0;
      rst[s] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst[s] = 1'b0;
      model_reset(s);
      model_view();
   endtask

   task automatic cycle(input logic w, input logic we, input logic [DW-1:0] d,
                        input logic r, input logic re, input logic c);
      logic          pop_m, push_m;
      logic [DW-1:0] pd;
      wr[sel] = w; wce[sel] = we; din[sel] = d; rd[sel] = r; rce[sel] = re; clr[sel] = c;
      push_m = 1'b0;
      pd     = '0;
      if (w && we && exp_full_n) begin
         due_q.push_back(cyc + lvl);
         dat_q.push_back(d);
      end
      pop_m = r && re && (q.size() != 0);
      if (due_q.size() != 0 && due_q[0] == cyc) begin
         push_m = 1'b1;
         pd     = dat_q.pop_front();
         void'(due_q.pop_front());
      end
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
         if (q.size() < cap) q.push_back(pd);
         else m_ovf = 1'b1;
      end
      if (c) mmax = 0;
      else if (q.size() > mmax) mmax = q.size();
      cyc++;
      @(posedge clk);
      @(negedge clk);
      model_view();
   endtask

   task automatic test_reset();
      do_reset(0);
      checks += 6;
      if (full_n[0] !== 1'b0) begin errors++; $display("FAIL reset_full_n: got %b expected 0", full_n[0]); end
      if (empty_n[0] !== 1'b0) begin errors++; $display("FAIL reset_empty_n: got %b expected 0", empty_n[0]); end
      if (occ[0] !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occ[0]); end
      if (mx[0] !== 4'd0) begin errors++; $display("FAIL reset_max: got %0d expected 0", mx[0]); end
      if (ovf[0] !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf[0]); end
      if (full_n[2] !== 1'b1) begin errors++; $display("FAIL reset_full_n_lvl0: got %b expected 1", full_n[2]); end
      cycle(0, 0, '0, 0, 0, 0);
      checks++;
      if (full_n[0] !== 1'b0) begin errors++; $display("FAIL full_n_cycle1: got %b expected 0", full_n[0]); end
      cycle(0, 0, '0, 0, 0, 0);
      checks++;
      if (full_n[0] !== 1'b1) begin errors++; $display("FAIL full_n_cycle2: got %b expected 1", full_n[0]); end
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_latency();
      do_reset(0);
      for (int n = 0; n < 5; n++) cycle(0, 0, '0, 0, 0, 0);
      cycle(1, 1, 16'hABCD, 0, 0, 0);
      cycle(0, 0, '0, 0, 0, 0);
      checks++;
      if (empty_n[0] !== 1'b0) begin errors++; $display("FAIL lat_empty_c7: got %b expected 0", empty_n[0]); end
      cycle(0, 0, '0, 0, 0, 0);
      checks += 3;
      if (empty_n[0] !== 1'b1) begin errors++; $display("FAIL lat_empty_c8: got %b expected 1", empty_n[0]); end
      if (dout[0] !== 16'hABCD) begin errors++; $display("FAIL lat_dout_c8: got %h expected abcd", dout[0]); end
      if (occ[0] !== 4'd1) begin errors++; $display("FAIL lat_occ_c8: got %0d expected 1", occ[0]); end
      cycle(0, 0, '0, 1, 1, 0);
      checks += 2;
      if (empty_n[0] !== 1'b0) begin errors++; $display("FAIL lat_empty_c9: got %b expected 0", empty_n[0]); end
      if (occ[0] !== 4'd0) begin errors++; $display("FAIL lat_occ_c9: got %0d expected 0", occ[0]); end
      $display("test_latency done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_fill();
      int t4;
      do_reset(0);
      t4 = -1;
      for (int n = 0; n < 30; n++) begin
         checks += 2;
         if (full_n[0] !== exp_full_n) begin errors++; $display("FAIL fill_full_n c%0d: got %b expected %b", n, full_n[0], exp_full_n); end
         if (occ[0] !== 4'(exp_occ)) begin errors++; $display("FAIL fill_occ c%0d: got %0d expected %0d", n, occ[0], exp_occ); end
         if (t4 < 0 && exp_occ == 4) t4 = n;
         if (t4 >= 0 && n == t4 + 1) begin
            checks++;
            if (full_n[0] !== 1'b1) begin errors++; $display("FAIL fill_full_n_t+1: got %b expected 1", full_n[0]); end
         end
         if (t4 >= 0 && n == t4 + 2) begin
            checks++;
            if (full_n[0] !== 1'b0) begin errors++; $display("FAIL fill_full_n_t+2: got %b expected 0", full_n[0]); end
         end
         cycle(1, 1, 16'(16'h1000 + n), 0, 0, 0);
      end
      checks += 4;
      if (occ[0] !== 4'd8) begin errors++; $display("FAIL fill_occ_final: got %0d expected 8", occ[0]); end
      if (mx[0] !== 4'd8) begin errors++; $display("FAIL fill_max: got %0d expected 8", mx[0]); end
      if (ovf[0] !== 1'b0) begin errors++; $display("FAIL fill_ovf: got %b expected 0", ovf[0]); end
      if (full_n[0] !== 1'b0) begin errors++; $display("FAIL fill_full_n_final: got %b expected 0", full_n[0]); end
      // Writes start landing at cycle 2, so the stored words are 0x1002..0x1009.
      for (int k = 0; k < 8; k++) begin
         checks += 2;
         if (empty_n[0] !== 1'b1) begin errors++; $display("FAIL drain_empty %0d: got %b expected 1", k, empty_n[0]); end
         if (dout[0] !== 16'(16'h1002 + k)) begin errors++; $display("FAIL drain_dout %0d: got %h expected %h", k, dout[0], 16'(16'h1002 + k)); end
         cycle(0, 0, '0, 1, 1, 0);
      end
      checks += 2;
      if (empty_n[0] !== 1'b0) begin errors++; $display("FAIL drain_empty_end: got %b expected 0", empty_n[0]); end
      if (mx[0] !== 4'd8) begin errors++; $display("FAIL drain_max: got %0d expected 8", mx[0]); end
      $display("test_fill done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_full_clear();
      do_reset(1);
      for (int n = 0; n < 20; n++) begin
         checks += 2;
         if (full_n[1] !== exp_full_n) begin errors++; $display("FAIL full_full_n c%0d: got %b expected %b", n, full_n[1], exp_full_n); end
         if (occ[1] !== 4'(exp_occ)) begin errors++; $display("FAIL full_occ c%0d: got %0d expected %0d", n, occ[1], exp_occ); end
         cycle(1, 1, 16'(16'h2000 + n), 0, 0, 0);
      end
      checks += 5;
      if (occ[1] !== 4'd7) begin errors++; $display("FAIL full_occ7: got %0d expected 7", occ[1]); end
      if (mx[1] !== 4'd7) begin errors++; $display("FAIL full_max7: got %0d expected 7", mx[1]); end
      if (ovf[1] !== 1'b0) begin errors++; $display("FAIL full_ovf: got %b expected 0", ovf[1]); end
      if (full_n[1] !== 1'b0) begin errors++; $display("FAIL full_full_n: got %b expected 0", full_n[1]); end
      if (dout[1] !== 16'h2001) begin errors++; $display("FAIL full_head: got %h expected 2001", dout[1]); end
      cycle(1, 1, 16'h2EEE, 1, 1, 0);
      checks += 3;
      if (occ[1] !== 4'd6) begin errors++; $display("FAIL full_pop_occ: got %0d expected 6", occ[1]); end
      if (dout[1] !== 16'h2002) begin errors++; $display("FAIL full_pop_head: got %h expected 2002", dout[1]); end
      if (ovf[1] !== 1'b0) begin errors++; $display("FAIL full_pop_ovf: got %b expected 0", ovf[1]); end
      cycle(0, 0, '0, 0, 0, 1);
      checks++;
      if (mx[1] !== 4'd0) begin errors++; $display("FAIL clear_max: got %0d expected 0", mx[1]); end
      cycle(0, 0, '0, 0, 0, 0);
      checks++;
      if (mx[1] !== 4'd6) begin errors++; $display("FAIL clear_max_track: got %0d expected 6", mx[1]); end
      $display("test_full_clear done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_midstream();
      int guard;
      do_reset(0);
      guard = 0;
      while (exp_occ != 5 && guard < 50) begin
         cycle(1, 1, 16'(16'h3000 + guard), 0, 0, 0);
         guard++;
      end
      checks++;
      if (guard >= 50) begin errors++; $display("FAIL mid_fill_timeout: got %0d cycles expected <50", guard); end
      checks++;
      if (occ[0] !== 4'd5) begin errors++; $display("FAIL mid_occ5: got %0d expected 5", occ[0]); end
      wr[0] = 1'b0;
      rst[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks += 5;
      if (empty_n[0] !== 1'b0) begin errors++; $display("FAIL mid_empty: got %b expected 0", empty_n[0]); end
      if (occ[0] !== 4'd0) begin errors++; $display("FAIL mid_occ: got %0d expected 0", occ[0]); end
      if (ovf[0] !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", ovf[0]); end
      if (mx[0] !== 4'd0) begin errors++; $display("FAIL mid_max: got %0d expected 0", mx[0]); end
      if (full_n[0] !== 1'b0) begin errors++; $display("FAIL mid_full_n: got %b expected 0", full_n[0]); end
      rst[0] = 1'b0;
      model_reset(0);
      model_view();
      for (int n = 0; n < 10; n++) begin
         checks += 2;
         if (empty_n[0] !== 1'b0) begin errors++; $display("FAIL mid_stale_empty c%0d: got %b expected 0", n, empty_n[0]); end
         if (occ[0] !== 4'd0) begin errors++; $display("FAIL mid_stale_occ c%0d: got %0d expected 0", n, occ[0]); end
         cycle(0, 0, '0, 1, 1, 0);
      end
      $display("test_reset_midstream done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_level0();
      do_reset(2);
      checks += 2;
      if (full_n[2] !== 1'b1) begin errors++; $display("FAIL l0_full_n_c0: got %b expected 1", full_n[2]); end
      if (empty_n[2] !== 1'b0) begin errors++; $display("FAIL l0_empty_c0: got %b expected 0", empty_n[2]); end
      cycle(1, 1, 16'h4000, 0, 0, 0);
      checks += 3;
      if (empty_n[2] !== 1'b1) begin errors++; $display("FAIL l0_latency: got %b expected 1", empty_n[2]); end
      if (dout[2] !== 16'h4000) begin errors++; $display("FAIL l0_dout: got %h expected 4000", dout[2]); end
      if (occ[2] !== 4'd1) begin errors++; $display("FAIL l0_occ1: got %0d expected 1", occ[2]); end
      cycle(1, 1, 16'h4001, 0, 0, 0);
      checks += 2;
      if (occ[2] !== 4'd2) begin errors++; $display("FAIL l0_occ2: got %0d expected 2", occ[2]); end
      if (full_n[2] !== 1'b1) begin errors++; $display("FAIL l0_full_n_c2: got %b expected 1", full_n[2]); end
      cycle(1, 1, 16'h4002, 0, 0, 0);
      checks += 2;
      if (occ[2] !== 4'd3) begin errors++; $display("FAIL l0_occ3: got %0d expected 3", occ[2]); end
      if (full_n[2] !== 1'b0) begin errors++; $display("FAIL l0_full_n_c3: got %b expected 0", full_n[2]); end
      cycle(1, 1, 16'h4003, 0, 0, 0);
      checks++;
      if (occ[2] !== 4'd3) begin errors++; $display("FAIL l0_ignored: got %0d expected 3", occ[2]); end
      cycle(0, 0, '0, 1, 1, 0);
      checks += 3;
      if (occ[2] !== 4'd2) begin errors++; $display("FAIL l0_pop_occ: got %0d expected 2", occ[2]); end
      if (full_n[2] !== 1'b1) begin errors++; $display("FAIL l0_pop_full_n: got %b expected 1", full_n[2]); end
      if (dout[2] !== 16'h4001) begin errors++; $display("FAIL l0_pop_dout: got %h expected 4001", dout[2]); end
      $display("test_level0 done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_random_stream();
      int   next_word, n_read, n;
      logic w, we, r, re, c, acc;
      do_reset(1);
      next_word = 0;
      n_read    = 0;
      n         = 0;
      while (n_read < 10000 && n < 60000 && errors < 50) begin
         checks += 5;
         if (full_n[1] !== exp_full_n) begin errors++; $display("FAIL rnd_full_n c%0d: got %b expected %b", n, full_n[1], exp_full_n); end
         if (empty_n[1] !== exp_empty_n) begin errors++; $display("FAIL rnd_empty_n c%0d: got %b expected %b", n, empty_n[1], exp_empty_n); end
         if (occ[1] !== 4'(exp_occ)) begin errors++; $display("FAIL rnd_occ c%0d: got %0d expected %0d", n, occ[1], exp_occ); end
         if (mx[1] !== 4'(exp_max)) begin errors++; $display("FAIL rnd_max c%0d: got %0d expected %0d", n, mx[1], exp_max); end
         if (ovf[1] !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d: got %b expected %b", n, ovf[1], m_ovf); end
         if (exp_empty_n) begin
            checks += 2;
            if (dout[1] !== exp_dout) begin errors++; $display("FAIL rnd_dout c%0d: got %h expected %h", n, dout[1], exp_dout); end
            if (dout[1] !== 16'(n_read)) begin errors++; $display("FAIL rnd_order c%0d: got %h expected %h", n, dout[1], 16'(n_read)); end
         end
         w   = (next_word < 10000) && ($urandom_range(99) < 70);
         we  = ($urandom_range(99) < 80);
         r   = ($urandom_range(99) < 60);
         re  = ($urandom_range(99) < 80);
         c   = ($urandom_range(99) < 2);
         acc = w && we && exp_full_n;
         if (r && re && exp_empty_n) n_read++;
         cycle(w, we, 16'(next_word), r, re, c);
         if (acc) next_word++;
         n++;
      end
      checks++;
      if (n_read != 10000) begin errors++; $display("FAIL rnd_words_read: got %0d expected 10000", n_read); end
      $display("test_random_stream done: cycles=%0d checks=%0d errors=%0d", n, checks, errors);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; wr[i] = 1'b0; wce[i] = 1'b0; rd[i] = 1'b0;
         rce[i] = 1'b0; clr[i] = 1'b0; din[i] = '0;
      end
      repeat (3) @(posedge clk);
      test_reset();
      test_latency();
      test_fill();
      test_full_clear();
      test_reset_midstream();
      test_level0();
      test_random_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
